// File: rtl/led_step_scheduler.sv
// Run/pause/speed/direction sequencer for the LED chaser: walks a one-hot
// position through the LED vector and counts laps up to an optional limit.
module led_step_scheduler #(
    parameter int WIDTH    = 24,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_evt,
    input  logic             clear_evt,
    input  logic             speed_up_evt,
    input  logic             speed_dn_evt,
    input  logic             dir_evt,
    input  logic [7:0]       laps_target,
    output logic [WIDTH-1:0] led,
    output logic             running,
    output logic [1:0]       speed,
    output logic             dir,
    output logic [7:0]       lap_count,
    output logic             lap_done,
    output logic             finished
);

    localparam int               PW       = $clog2(TICK_DIV);
    localparam logic [WIDTH-1:0] LED_HOME = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       speed_q, speed_d;
    logic             dir_q, dir_d;
    logic [7:0]       lap_q, lap_d;
    logic [7:0]       target_q, target_d;
    logic             lap_done_q, lap_done_d;
    logic             finished_q, finished_d;
    logic             running_q, running_d;

    logic [PW-1:0]    limit;
    logic             step_due;
    logic             spd_inc;
    logic             spd_dec;
    logic             wrap;
    logic [7:0]       lap_inc;
    logic [WIDTH-1:0] led_rot;

    // Step limit halves with each speed level.
    always_comb begin
        limit    = PW'((TICK_DIV >> speed_q) - 1);
        step_due = (state_q == S_RUN) && (presc_q == limit);
        spd_inc  = speed_up_evt && !speed_dn_evt && (speed_q != 2'd3);
        spd_dec  = speed_dn_evt && !speed_up_evt && (speed_q != 2'd0);
        wrap     = dir_q ? led_q[0] : led_q[WIDTH-1];
        lap_inc  = lap_q + 8'd1;
        led_rot  = dir_q ? {led_q[0], led_q[WIDTH-1:1]}
                         : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d    = state_q;
        led_d      = led_q;
        presc_d    = presc_q;
        speed_d    = speed_q;
        dir_d      = dir_q;
        lap_d      = lap_q;
        target_d   = target_q;
        lap_done_d = 1'b0;
        finished_d = 1'b0;

        if (clear_evt) begin
            state_d = S_IDLE;
            led_d   = LED_HOME;
            presc_d = '0;
            lap_d   = '0;
        end else if (start_evt) begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_RUN;
                    presc_d  = '0;
                    lap_d    = '0;
                    target_d = laps_target;
                end
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                S_DONE: begin
                    state_d = S_IDLE;
                    led_d   = LED_HOME;
                    lap_d   = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            if (spd_inc) speed_d = speed_q + 2'd1;
            if (spd_dec) speed_d = speed_q - 2'd1;
            if (dir_evt) dir_d = ~dir_q;

            // An effective speed change restarts the step period.
            if (spd_inc || spd_dec || step_due) begin
                presc_d = '0;
            end else if (state_q == S_RUN) begin
                presc_d = presc_q + PW'(1);
            end

            if (step_due) begin
                led_d = led_rot;
                if (wrap) begin
                    lap_done_d = 1'b1;
                    lap_d      = lap_inc;
                    if ((target_q != 8'd0) && (lap_inc == target_q)) begin
                        state_d    = S_DONE;
                        led_d      = '1;
                        finished_d = 1'b1;
                    end
                end
            end
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            led_q      <= LED_HOME;
            presc_q    <= '0;
            speed_q    <= '0;
            dir_q      <= 1'b0;
            lap_q      <= '0;
            target_q   <= '0;
            lap_done_q <= 1'b0;
            finished_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates together on the edge.
            state_q    <= state_d;
            led_q      <= led_d;
            presc_q    <= presc_d;
            speed_q    <= speed_d;
            dir_q      <= dir_d;
            lap_q      <= lap_d;
            target_q   <= target_d;
            lap_done_q <= lap_done_d;
            finished_q <= finished_d;
            running_q  <= running_d;
        end
    end

    assign led       = led_q;
    assign running   = running_q;
    assign speed     = speed_q;
    assign dir       = dir_q;
    assign lap_count = lap_q;
    assign lap_done  = lap_done_q;
    assign finished  = finished_q;

endmodule

// File: doc/led_step_scheduler.md
# led_step_scheduler

Run/pause/speed/direction controller for the 24-bit LED chaser. Sits between the button debouncers (one-cycle `trans_dn` event pulses) and the LED output mask. It sequences a one-hot position through the LED vector at a selectable rate and in either direction. It counts laps and stops after a programmed number of laps.

## Interface
- `WIDTH`, 24, LED vector width (≥2)
- `TICK_DIV`, 50_000_000, step period in CLK cycles at speed 0 (1 s at 50 MHz); must be divisible by 8
- `CLK`  in  1  system clock, all state on rising edge
- `RST`  in  1  reset; asynchronous, active-high
- `start_evt`  in  1  one-cycle pulse: start / pause / resume / acknowledge done
- `clear_evt`  in  1  one-cycle pulse: abort to IDLE from any state
- `speed_up_evt`  in  1  one-cycle pulse: speed +1, saturating at 3
- `speed_dn_evt`  in  1  one-cycle pulse: speed −1, saturating at 0
- `dir_evt`  in  1  one-cycle pulse: toggle direction
- `laps_target`  in  8  lap limit, 0 = run forever; latched on IDLE→RUN
- `led`  out  WIDTH  one-hot position (all ones in DONE)
- `running`  out  1  high in RUN only
- `speed`  out  2  current speed level
- `dir`  out  1  0 = toward MSB (shift left), 1 = toward LSB
- `lap_count`  out  8  completed laps this run, wraps 255→0 when target is 0
- `lap_done`  out  1  one-cycle pulse on each wrap
- `finished`  out  1  one-cycle pulse on entering DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset values: IDLE, `led`=1, `running`=0, `speed`=0, `dir`=0, `lap_count`=0, prescaler=0, pulses 0.
- Event priority per cycle: `clear_evt` > `start_evt` > speed/dir events. `speed_up_evt` and `speed_dn_evt` in the same cycle cancel each other (no change).
- IDLE: `led`=1. `start_evt` → RUN, prescaler=0, `lap_count`=0, latch `laps_target`.
- RUN: the prescaler increments each cycle. Limit L = (TICK_DIV>>speed)−1. When prescaler==L: prescaler←0 and step.
  - Step with `dir`=0: `led`←`led`<<1. From the MSB it wraps to bit 0.
  - Step with `dir`=1: `led`←`led`>>1. From bit 0 it wraps to the MSB.
  - Wrap: `lap_done` pulses and `lap_count`+1. If latched target≠0 and new count==target: → DONE, `led`←all ones, `finished` pulses (together with `lap_done`).
- `start_evt` in RUN → PAUSE. The prescaler and `led` hold. Any step due that cycle is suppressed.
- PAUSE: `start_evt` → RUN. The prescaler resumes from its held value.
- DONE: `start_evt` → IDLE (`led`=1, `lap_count`=0). `lap_count` holds its final value while in DONE.
- `clear_evt` in any state → IDLE, prescaler=0, `lap_count`=0. `speed` and `dir` are kept.
- Speed change is allowed in any state. An effective change (value actually changes) clears the prescaler to 0. If it coincides with a step, the step still happens.
- Direction toggle is allowed in any state. It takes effect at the next step; the current `led` is unchanged.
- `laps_target` changes after the start are ignored until the next IDLE→RUN.

## Timing
- All outputs are registered. Events are sampled on the rising edge at which they are high.
- First step: `led` changes exactly TICK_DIV>>speed edges after the edge that sampled `start_evt` (IDLE→RUN).
- Steady step period is TICK_DIV>>speed cycles: speed 0 = 1×, speed 1 = ½, speed 2 = ¼, speed 3 = ⅛.
- Resume from PAUSE with held prescaler p: the step occurs L−p+1 edges after the resume edge.
- `lap_done` and `finished` are high for exactly one cycle, coincident with the wrapped `led` value.
- RST asserted at any time forces all reset values immediately, with no clock needed. The first event is accepted on the first edge after deassertion.

## Test plan
Parameters for all tests: WIDTH=4, TICK_DIV=8.
- Reset: assert RST mid-RUN with `led`=0100 → `led`=0001, `running`=0, `lap_count`=0 immediately; release, no events → `led` stays 0001.
- Basic run, speed 0, `dir`=0, target 0: `start_evt` → `led` 0010 at +8, 0100 at +16, 1000 at +24, 0001 at +32 with one-cycle `lap_done`, `lap_count`=1.
- Lap limit: `laps_target`=2, start → at +64 `led`=1111, `finished` and `lap_done` pulse, `running`=0. Then `start_evt` → `led`=0001, `lap_count`=0.
- Speed: three `speed_up_evt` → `speed`=3, `led` steps every cycle. Fourth pulse → `speed` stays 3. Four `speed_dn_evt` → `speed`=0, period 8. Both events in one cycle → no change.
- Direction: `dir_evt` while `led`=0100 → next steps 0010, 0001, 1000, with `lap_done` on the 0001→1000 wrap.
- Pause/resume: `start_evt` at `led`=0010 with prescaler=5 → 100 cycles of no change. Resume → `led`=0100 exactly 3 edges later. `clear_evt` together with `start_evt` → IDLE, `led`=0001.
